// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: load-use bubbles, redirect flushes, memory-wait freeze and trap drain.
// Control outputs are combinational on current state/inputs; counters and state update on the clock.
module pipeline_hazard_controller #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      ID_rs1,
  input  logic [4:0]      ID_rs2,
  input  logic            ID_uses_rs1,
  input  logic            ID_uses_rs2,
  input  logic [4:0]      EX_rd,
  input  logic            EX_memory_read,
  input  logic            EX_branch_mispredict,
  input  logic            EX_jump,
  input  logic            trap_request,
  input  logic            trap_done,
  input  logic            dmem_busy,
  output logic            pc_stall,
  output logic            IF_ID_stall,
  output logic            ID_EX_stall,
  output logic            EX_MEM_stall,
  output logic            IF_ID_flush,
  output logic            ID_EX_flush,
  output logic            EX_MEM_flush,
  output logic            pc_redirect,
  output logic [1:0]      hazard_state,
  output logic [XLEN-1:0] stall_count,
  output logic [XLEN-1:0] flush_count
);

  typedef enum logic [1:0] {
    NORMAL     = 2'b00,
    MEM_WAIT   = 2'b01,
    TRAP_DRAIN = 2'b10,
    UNUSED     = 2'b11
  } state_t;

  state_t state, state_nxt;
  logic   trap_pending, trap_pending_nxt;
  logic   load_use;
  logic   normal_rules;
  logic   trap_eff;

  assign load_use = EX_memory_read && (EX_rd != 5'd0) &&
                    ((ID_uses_rs1 && (ID_rs1 == EX_rd)) ||
                     (ID_uses_rs2 && (ID_rs2 == EX_rd)));

  assign hazard_state = state;

  always_comb begin
    pc_stall         = 1'b0;
    IF_ID_stall      = 1'b0;
    ID_EX_stall      = 1'b0;
    EX_MEM_stall     = 1'b0;
    IF_ID_flush      = 1'b0;
    ID_EX_flush      = 1'b0;
    EX_MEM_flush     = 1'b0;
    pc_redirect      = 1'b0;
    state_nxt        = NORMAL;
    trap_pending_nxt = trap_pending;
    normal_rules     = 1'b0;
    trap_eff         = 1'b0;

    case (state)
      NORMAL: normal_rules = 1'b1;
      MEM_WAIT: begin
        if (dmem_busy) begin
          // EX is frozen, so redirects wait; a trap is remembered until memory releases.
          {pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall} = 4'b1111;
          state_nxt = MEM_WAIT;
          if (trap_request) trap_pending_nxt = 1'b1;
        end else begin
          normal_rules = 1'b1;
        end
      end
      TRAP_DRAIN: begin
        if (trap_done) begin
          pc_redirect = 1'b1;
          state_nxt   = NORMAL;
        end else begin
          pc_stall    = 1'b1;
          IF_ID_flush = 1'b1;
          ID_EX_flush = 1'b1;
          state_nxt   = TRAP_DRAIN;
        end
      end
      default: state_nxt = NORMAL;
    endcase

    if (normal_rules) begin
      trap_eff         = trap_request || trap_pending;
      trap_pending_nxt = 1'b0;
      if (trap_eff) begin
        pc_stall     = 1'b1;
        IF_ID_flush  = 1'b1;
        ID_EX_flush  = 1'b1;
        EX_MEM_flush = 1'b1;
        state_nxt    = TRAP_DRAIN;
      end else if (dmem_busy) begin
        {pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall} = 4'b1111;
        state_nxt = MEM_WAIT;
      end else if (EX_branch_mispredict || EX_jump) begin
        IF_ID_flush = 1'b1;
        ID_EX_flush = 1'b1;
        pc_redirect = 1'b1;
      end else if (load_use) begin
        pc_stall    = 1'b1;
        IF_ID_stall = 1'b1;
        ID_EX_flush = 1'b1;
      end
    end

    if (reset) begin
      {pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall} = 4'b0000;
      {IF_ID_flush, ID_EX_flush, EX_MEM_flush, pc_redirect} = 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= NORMAL;
      trap_pending <= 1'b0;
      stall_count  <= '0;
      flush_count  <= '0;
    end else begin
      state        <= state_nxt;
      trap_pending <= trap_pending_nxt;
      if (pc_stall && (stall_count != '1)) stall_count <= stall_count + XLEN'(1);
      if (ID_EX_flush && (flush_count != '1)) flush_count <= flush_count + XLEN'(1);
    end
  end

endmodule
